// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - shared rename-stage parameters and physical register type
package rename_pkg;

    localparam int NUM_PREG = 64;
    localparam int NUM_AREG = 32;
    localparam int PREG_W   = $clog2(NUM_PREG);
    localparam int FL_DEPTH = NUM_PREG - NUM_AREG;
    localparam int FL_PTR_W = $clog2(FL_DEPTH);

    typedef logic [PREG_W-1:0]   preg_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;
    // Free count spans 0..FL_DEPTH, which fits in PREG_W bits.
    typedef logic [PREG_W-1:0]   fl_cnt_t;

endpackage

// File: rtl/preg_free_list.sv
// rtl/preg_free_list.sv - physical register free list with busy tracking and double-free guard
module preg_free_list
    import rename_pkg::*;
(
    input  logic    clk,
    input  logic    rstn,
    input  logic    alloc_req,
    output logic    alloc_gnt,
    output preg_t   alloc_preg,
    input  logic    rel_valid,
    input  preg_t   rel_preg,
    output logic    empty,
    output fl_cnt_t free_count,
    output logic    dbl_free_err
);

    preg_t                fifo_q [FL_DEPTH];
    fl_ptr_t              head_q, head_d;
    fl_ptr_t              tail_q, tail_d;
    fl_cnt_t              count_q, count_d;
    logic [NUM_PREG-1:0]  busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 rel_nonzero;
    logic                 rel_legal;
    logic                 rel_dbl;

    // Grant path depends only on registered state and alloc_req; releases never bypass.
    always_comb begin
        alloc_gnt   = alloc_req && (count_q != '0);
        alloc_preg  = fifo_q[head_q];
        empty       = (count_q == '0);
        rel_nonzero = rel_valid && (rel_preg != '0);
        rel_legal   = rel_nonzero && busy_q[rel_preg];
        rel_dbl     = rel_nonzero && !busy_q[rel_preg];
    end

    // Next-state for pointers, count, busy vector and sticky error.
    // A granted preg was free and a legally released one was busy, so the
    // two busy updates can never target the same bit.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        busy_d  = busy_q;
        err_d   = err_q || rel_dbl;
        if (alloc_gnt) begin
            head_d              = head_q + fl_ptr_t'(1);
            busy_d[alloc_preg]  = 1'b1;
        end
        if (rel_legal) begin
            tail_d              = tail_q + fl_ptr_t'(1);
            busy_d[rel_preg]    = 1'b0;
        end
        if (rel_legal && !alloc_gnt) begin
            count_d = count_q + fl_cnt_t'(1);
        end else if (!rel_legal && alloc_gnt) begin
            count_d = count_q - fl_cnt_t'(1);
        end
    end

    // State registers; reset preloads the pool with the unmapped pregs in order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                fifo_q[i] <= preg_t'(NUM_AREG + i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= fl_cnt_t'(FL_DEPTH);
            busy_q  <= {{(NUM_PREG-NUM_AREG){1'b0}}, {NUM_AREG{1'b1}}};
            err_q   <= 1'b0;
        end else begin
            if (rel_legal) begin
                fifo_q[tail_q] <= rel_preg;
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign free_count   = count_q;
    assign dbl_free_err = err_q;

endmodule

// File: tb/tb_preg_free_list.sv
// tb/tb_preg_free_list.sv - directed vector bench for preg_free_list
module tb_preg_free_list;
    import rename_pkg::*;

    logic    clk;
    logic    rstn;
    logic    alloc_req;
    logic    alloc_gnt;
    preg_t   alloc_preg;
    logic    rel_valid;
    preg_t   rel_preg;
    logic    empty;
    fl_cnt_t free_count;
    logic    dbl_free_err;

    int n_vec;
    int n_bad;
    logic [NUM_PREG-1:0] mbusy;

    typedef struct {
        logic  areq;
        logic  rv;
        preg_t rp;
        logic  egnt;
        preg_t epreg;
        logic  eempty;
        int    ecnt;
        logic  eerr;
    } vec_t;

    vec_t tbl [7];

    preg_free_list dut (
        .clk          (clk),
        .rstn         (rstn),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_preg   (alloc_preg),
        .rel_valid    (rel_valid),
        .rel_preg     (rel_preg),
        .empty        (empty),
        .free_count   (free_count),
        .dbl_free_err (dbl_free_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called at posedge+1: drive, check combinational outputs, clock, check registered outputs.
    task automatic step(input logic areq, input logic rv, input preg_t rp,
                        input logic egnt, input preg_t ep, input logic eempty,
                        input int ecnt, input logic eerr, input string nm);
        alloc_req = areq;
        rel_valid = rv;
        rel_preg  = rp;
        #2;
        n_vec++;
        chk({nm, ".gnt"}, int'(alloc_gnt), int'(egnt));
        if (egnt) chk({nm, ".preg"}, int'(alloc_preg), int'(ep));
        chk({nm, ".empty"}, int'(empty), int'(eempty));
        if (alloc_gnt) begin
            chk({nm, ".dup"}, int'(mbusy[alloc_preg]), 0);
            mbusy[alloc_preg] = 1'b1;
        end
        if (rv && rp != '0 && mbusy[rp]) mbusy[rp] = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, ".cnt"}, int'(free_count), ecnt);
        chk({nm, ".err"}, int'(dbl_free_err), int'(eerr));
    endtask

    task automatic do_reset();
        @(negedge clk);
        alloc_req = 1'b0;
        rel_valid = 1'b0;
        rel_preg  = '0;
        #2;
        rstn = 1'b0;
        #1;
        n_vec++;
        chk("rst.gnt", int'(alloc_gnt), 0);
        chk("rst.preg", int'(alloc_preg), NUM_AREG);
        chk("rst.empty", int'(empty), 0);
        chk("rst.cnt", int'(free_count), FL_DEPTH);
        chk("rst.err", int'(dbl_free_err), 0);
        mbusy = {{(NUM_PREG-NUM_AREG){1'b0}}, {NUM_AREG{1'b1}}};
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rstn      = 1'b1;
        alloc_req = 1'b0;
        rel_valid = 1'b0;
        rel_preg  = '0;

        //          areq rv  rp      gnt  preg    empty cnt err
        tbl[0] = '{1'b0, 1'b0, 6'd0,  1'b0, 6'd32, 1'b0, 32, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 6'd0,  1'b1, 6'd32, 1'b0, 31, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 6'd7,  1'b1, 6'd33, 1'b0, 31, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 6'd0,  1'b0, 6'd34, 1'b0, 31, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 6'd0,  1'b1, 6'd34, 1'b0, 30, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 6'd32, 1'b0, 6'd35, 1'b0, 31, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 6'd40, 1'b0, 6'd35, 1'b0, 31, 1'b1};

        // Table: single grants, grant+release, x0 release, double free.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].areq, tbl[i].rv, tbl[i].rp, tbl[i].egnt, tbl[i].epreg,
                 tbl[i].eempty, tbl[i].ecnt, tbl[i].eerr, $sformatf("tbl%0d", i));
        end
        // Drain: p35..p63, then p7 from tail slot 0, then p32 from slot 1.
        for (int i = 0; i < 31; i++) begin
            step(1'b1, 1'b0, '0, 1'b1, (i < 29) ? preg_t'(35 + i) : ((i == 29) ? 6'd7 : 6'd32),
                 1'b0, 30 - i, 1'b1, $sformatf("drain%0d", i));
        end
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 0, 1'b1, "drain_empty");

        // Fresh pool: 32 grants in order, then the 33rd is refused.
        do_reset();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, '0, 1'b1, preg_t'(32 + i), 1'b0, 31 - i, 1'b0,
                 $sformatf("fill%0d", i));
        end
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 0, 1'b0, "req33");
        // Release into an empty pool does not bypass; granted the next cycle.
        step(1'b1, 1'b1, 6'd5, 1'b0, '0, 1'b1, 1, 1'b0, "nobypass");
        step(1'b1, 1'b0, '0, 1'b1, 6'd5, 1'b0, 0, 1'b0, "regrant5");
        // Wrap: release odd pregs high to low, grants must follow release order.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, preg_t'(63 - 2*i), 1'b0, '0, (i == 0), i + 1, 1'b0,
                 $sformatf("wrel%0d", i));
        end
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, '0, 1'b1, preg_t'(63 - 2*i), 1'b0, 31 - i, 1'b0,
                 $sformatf("walloc%0d", i));
        end

        // Double free right after reset: sticky across traffic, cleared by reset.
        do_reset();
        step(1'b0, 1'b1, 6'd40, 1'b0, '0, 1'b0, 32, 1'b1, "dbl40");
        step(1'b1, 1'b0, '0, 1'b1, 6'd32, 1'b0, 31, 1'b1, "sticky_a");
        step(1'b1, 1'b1, 6'd3, 1'b1, 6'd33, 1'b0, 31, 1'b1, "sticky_b");
        step(1'b0, 1'b1, 6'd0, 1'b0, '0, 1'b0, 31, 1'b1, "x0rel");
        do_reset();
        step(1'b0, 1'b1, 6'd0, 1'b0, '0, 1'b0, 32, 1'b0, "x0_clean");
        step(1'b1, 1'b0, '0, 1'b1, 6'd32, 1'b0, 31, 1'b0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/preg_free_list.md
# preg_free_list

Physical-register free-list controller for the rename stage. It owns the pool of unmapped physical registers and hands one out per cycle to rename for a non-x0 destination. It reclaims the previous mapping of a destination when the ROB commits the instruction. It also tracks a busy bit per physical register, so that a double release is caught and blocked instead of corrupting the pool.

## Interface
- NUM_PREG, 64, total physical registers.
- NUM_AREG, 32, architectural registers; p0..p(NUM_AREG-1) are mapped at reset.
- PREG_W, 6, physical register index width, equal to clog2(NUM_PREG).
- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- alloc_req  in  1  rename needs a destination preg this cycle.
- alloc_gnt  out  1  allocation accepted this cycle.
- alloc_preg  out  PREG_W  preg granted; valid only when alloc_gnt=1.
- rel_valid  in  1  ROB commit releases a preg this cycle.
- rel_preg  in  PREG_W  preg being released, i.e. the old mapping of the committed destination.
- empty  out  1  free count is 0.
- free_count  out  PREG_W  number of free entries, 0..NUM_PREG-NUM_AREG.
- dbl_free_err  out  1  sticky; set on an illegal release.

## Operation
- Storage:
  - Circular FIFO of depth D = NUM_PREG-NUM_AREG (32), each entry PREG_W bits.
  - head pointer and tail pointer, each clog2(D) bits, wrapping D-1 to 0.
  - Count register.
  - busy[NUM_PREG] bit vector.
- Reset (rstn=0, asynchronous):
  - entry[i] = NUM_AREG+i.
  - head=0, tail=0, count=D.
  - busy[0..NUM_AREG-1]=1, busy[NUM_AREG..NUM_PREG-1]=0.
  - dbl_free_err=0.
- Allocate:
  - alloc_gnt = alloc_req & (count!=0).
  - alloc_preg = entry[head].
  - On a grant: head advances by 1 and busy[alloc_preg] is set.
- Release: a release is legal when rel_valid=1, rel_preg!=0 and busy[rel_preg]=1.
  - Legal release: entry[tail] gets rel_preg, tail advances by 1, busy[rel_preg] is cleared.
  - rel_preg=0: ignored silently, because x0 is never renamed. No error is raised.
  - rel_valid with busy[rel_preg]=0: not pushed, and dbl_free_err is set and held until reset.
- Count update per cycle: +1 for a legal release, -1 for a grant, unchanged when both occur.
- Empty with a simultaneous legal release: no bypass. alloc_gnt stays 0 that cycle, and the released preg can be granted the next cycle at the earliest.
- Full (count=D) with a release: only reachable through a double free, which is blocked by the busy check. Count never exceeds D.

## Timing
- alloc_gnt, alloc_preg and empty are combinational from registered state plus alloc_req. They have no dependency on rel_valid or rel_preg.
- Allocation latency is 0 cycles, meaning the grant comes in the same cycle as the request. Back-to-back grants every cycle while count>0.
- Release-to-reallocation latency is 1 cycle minimum.
- free_count and dbl_free_err are registered.
- Output values during reset: alloc_gnt=0 (when alloc_req=0), alloc_preg=NUM_AREG, empty=0, free_count=D, dbl_free_err=0.
- Reset deasserted mid-stream: the first edge after deassertion follows normal rules. No init sequence and no warm-up cycles.

## Structure
- Shared package rename_pkg holds:
  - NUM_PREG, NUM_AREG, PREG_W, FL_DEPTH.
  - typedef preg_t as logic [PREG_W-1:0].
  - The preg_t type is shared with rename, ROB and the reservation stations.
- No sub-module. FIFO, pointer/count logic and busy vector are implemented inline. Expected size is about 150 lines.

## Test plan
- Reset, then 32 consecutive alloc_req cycles: grants return p32..p63 in order. After the last grant, empty=1 and free_count=0. The 33rd request gets alloc_gnt=0.
- Pool empty, then release p5 (busy at reset) while alloc_req=1: alloc_gnt=0 that cycle. The next cycle grants p5, and free_count goes 0 -> 1 -> 0.
- Reset, allocate p32, then in one cycle allocate and legally release p7: free_count stays 31, the grant is p33, and p7 is written at tail index 0.
- Release p40 while it is free after reset: dbl_free_err=1, free_count stays 32, and the error stays set through later traffic until rstn=0.
- Release p0 with rel_valid=1: no state change and dbl_free_err=0.
- Wrap: allocate 32, release 32, allocate 32 again. The grants come back in release order and head/tail wrap cleanly with no duplicates. Assert busy stays consistent with membership in the FIFO.
